// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX write-side hazard controller: load-use stalls, branch flushes,
// data-memory wait freezes with timeout, and stall/flush performance counters.
module id_ex_hazard_ctrl #(
    parameter int REG_BITS    = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_BITS-1:0]  IFID_Rs,
    input  logic [REG_BITS-1:0]  IFID_Rt,
    input  logic                 IFID_UsesRs,
    input  logic                 IFID_UsesRt,
    input  logic [REG_BITS-1:0]  IDEX_Rd,
    input  logic                 IDEX_MemRead,
    input  logic                 IDEX_WriteReg,
    input  logic                 BranchTaken,
    input  logic                 MemReq,
    input  logic                 MemDone,
    output logic                 PC_wen,
    output logic                 IFID_wen,
    output logic                 IFID_flush,
    output logic                 IDEX_wen,
    output logic                 IDEX_bubble,
    output logic                 EXMEM_wen,
    output logic                 MemErr,
    output logic [CNT_WIDTH-1:0] StallCnt,
    output logic [CNT_WIDTH-1:0] FlushCnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]    WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0]    WAIT_ZERO = WAIT_W'(0);
    localparam logic [WAIT_W-1:0]    WAIT_LIM  = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    state_t                 state_r;
    logic [WAIT_W-1:0]      waitCnt_r;
    logic [WAIT_W-1:0]      nextWait_s;
    logic [CNT_WIDTH-1:0]   stallCnt_r;
    logic [CNT_WIDTH-1:0]   flushCnt_r;
    logic                   loadUse_s;
    logic                   freeze_s;
    logic                   pcWen_s;
    logic                   ifidWen_s;
    logic                   ifidFlush_s;
    logic                   idexWen_s;
    logic                   idexBubble_s;
    logic                   exmemWen_s;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign loadUse_s = IDEX_MemRead & IDEX_WriteReg & (IDEX_Rd != {REG_BITS{1'b0}}) &
                       ((IFID_UsesRs & (IFID_Rs == IDEX_Rd)) |
                        (IFID_UsesRt & (IFID_Rt == IDEX_Rd)));

    assign nextWait_s = waitCnt_r + WAIT_ONE;

    // Pipeline-register enables; a pending memory access outranks branch and load-use.
    always_comb begin
        pcWen_s      = 1'b1;
        ifidWen_s    = 1'b1;
        ifidFlush_s  = 1'b0;
        idexWen_s    = 1'b1;
        idexBubble_s = 1'b0;
        exmemWen_s   = 1'b1;
        case (state_r)
            RUN:     freeze_s = MemReq & ~MemDone;
            MEMWAIT: freeze_s = ~MemDone;
            ERR:     freeze_s = 1'b1;
            default: freeze_s = 1'b1;
        endcase
        if (!rst) begin
            pcWen_s      = 1'b0;
            ifidWen_s    = 1'b0;
            idexWen_s    = 1'b0;
            exmemWen_s   = 1'b0;
            ifidFlush_s  = 1'b1;
            idexBubble_s = 1'b1;
        end else if (freeze_s) begin
            pcWen_s      = 1'b0;
            ifidWen_s    = 1'b0;
            idexWen_s    = 1'b0;
            exmemWen_s   = 1'b0;
        end else if (BranchTaken) begin
            ifidFlush_s  = 1'b1;
            idexBubble_s = 1'b1;
        end else if (loadUse_s) begin
            pcWen_s      = 1'b0;
            ifidWen_s    = 1'b0;
            idexBubble_s = 1'b1;
        end else begin
            idexBubble_s = 1'b0;
        end
    end

    // Memory-wait state machine with timeout into a sticky error state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= RUN;
            waitCnt_r <= WAIT_ZERO;
        end else begin
            case (state_r)
                RUN: begin
                    if (MemReq & ~MemDone) begin
                        state_r   <= MEMWAIT;
                        waitCnt_r <= WAIT_ONE;
                    end else begin
                        waitCnt_r <= WAIT_ZERO;
                    end
                end
                MEMWAIT: begin
                    if (MemDone) begin
                        state_r   <= RUN;
                        waitCnt_r <= WAIT_ZERO;
                    end else begin
                        waitCnt_r <= nextWait_s;
                        if (nextWait_s >= WAIT_LIM) begin
                            state_r <= ERR;
                        end
                    end
                end
                ERR: begin
                    state_r <= ERR;
                end
                default: begin
                    state_r   <= ERR;
                    waitCnt_r <= WAIT_ZERO;
                end
            endcase
        end
    end

    // Saturating stall and flush performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt_r <= {CNT_WIDTH{1'b0}};
            flushCnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (!pcWen_s && (stallCnt_r != CNT_MAX)) begin
                stallCnt_r <= stallCnt_r + CNT_ONE;
            end
            if (ifidFlush_s && (flushCnt_r != CNT_MAX)) begin
                flushCnt_r <= flushCnt_r + CNT_ONE;
            end
        end
    end

    assign PC_wen      = pcWen_s;
    assign IFID_wen    = ifidWen_s;
    assign IFID_flush  = ifidFlush_s;
    assign IDEX_wen    = idexWen_s;
    assign IDEX_bubble = idexBubble_s;
    assign EXMEM_wen   = exmemWen_s;
    assign MemErr      = (state_r == ERR);
    assign StallCnt    = stallCnt_r;
    assign FlushCnt    = flushCnt_r;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Self-checking bench for id_ex_hazard_ctrl: directed scenarios plus random
// traffic compared against a behavioural model of the hazard rules.
module tb_id_ex_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  IFID_Rs = 4'd0, IFID_Rt = 4'd0, IDEX_Rd = 4'd0;
    logic        IFID_UsesRs = 1'b0, IFID_UsesRt = 1'b0;
    logic        IDEX_MemRead = 1'b0, IDEX_WriteReg = 1'b0;
    logic        BranchTaken = 1'b0, MemReq = 1'b0, MemDone = 1'b0;
    logic        PC_wen, IFID_wen, IFID_flush, IDEX_wen, IDEX_bubble, EXMEM_wen, MemErr;
    logic [15:0] StallCnt, FlushCnt;

    int total = 0;
    int bad = 0;

    id_ex_hazard_ctrl #(.REG_BITS(4), .CNT_WIDTH(16), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_UsesRs(IFID_UsesRs), .IFID_UsesRt(IFID_UsesRt),
        .IDEX_Rd(IDEX_Rd), .IDEX_MemRead(IDEX_MemRead), .IDEX_WriteReg(IDEX_WriteReg),
        .BranchTaken(BranchTaken), .MemReq(MemReq), .MemDone(MemDone),
        .PC_wen(PC_wen), .IFID_wen(IFID_wen), .IFID_flush(IFID_flush),
        .IDEX_wen(IDEX_wen), .IDEX_bubble(IDEX_bubble), .EXMEM_wen(EXMEM_wen),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        IFID_Rs = 4'd0; IFID_Rt = 4'd0; IDEX_Rd = 4'd0;
        IFID_UsesRs = 1'b0; IFID_UsesRt = 1'b0;
        IDEX_MemRead = 1'b0; IDEX_WriteReg = 1'b0;
        BranchTaken = 1'b0; MemReq = 1'b0; MemDone = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        idle();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        @(negedge clk);
        #1;
        total++;
        if ({PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble} !== 6'b000011) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000011",
                     {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble});
        end
        total++;
        if ({MemErr, StallCnt, FlushCnt} !== 33'd0) begin
            bad++;
            $display("FAIL reset_state err=%b stall=%0d flush=%0d want 0/0/0", MemErr, StallCnt, FlushCnt);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble} !== 6'b111100) begin
            bad++;
            $display("FAIL post_reset_ctrl got=%b want=111100",
                     {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble});
        end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        doReset();
        IDEX_MemRead = 1'b1; IDEX_WriteReg = 1'b1; IDEX_Rd = 4'd3;
        IFID_Rs = 4'd3; IFID_UsesRs = 1'b1;
        #1;
        total++;
        if ({PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble} !== 6'b001101) begin
            bad++;
            $display("FAIL load_use_stall got=%b want=001101",
                     {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble});
        end
        @(negedge clk);
        IDEX_MemRead = 1'b0;
        #1;
        total++;
        if ({PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble} !== 6'b111100) begin
            bad++;
            $display("FAIL load_use_release got=%b want=111100",
                     {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble});
        end
        @(negedge clk);
        total++;
        if (StallCnt !== 16'd1) begin
            bad++;
            $display("FAIL load_use_stallcnt got=%0d want=1", StallCnt);
        end
        // Rt path with Rs not used.
        IDEX_MemRead = 1'b1; IFID_UsesRs = 1'b0; IFID_Rs = 4'd5;
        IFID_Rt = 4'd3; IFID_UsesRt = 1'b1;
        #1;
        total++;
        if ({PC_wen, IDEX_bubble} !== 2'b01) begin
            bad++;
            $display("FAIL load_use_rt got=%b want=01", {PC_wen, IDEX_bubble});
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_rd_zero();
        doReset();
        IDEX_MemRead = 1'b1; IDEX_WriteReg = 1'b1; IDEX_Rd = 4'd0;
        IFID_Rs = 4'd0; IFID_UsesRs = 1'b1;
        #1;
        total++;
        if ({PC_wen, IFID_wen, IDEX_bubble} !== 3'b110) begin
            bad++;
            $display("FAIL rd_zero_ctrl got=%b want=110", {PC_wen, IFID_wen, IDEX_bubble});
        end
        @(negedge clk);
        total++;
        if (StallCnt !== 16'd0) begin
            bad++;
            $display("FAIL rd_zero_stallcnt got=%0d want=0", StallCnt);
        end
        idle();
    endtask

    task automatic test_branch_loaduse();
        doReset();
        IDEX_MemRead = 1'b1; IDEX_WriteReg = 1'b1; IDEX_Rd = 4'd3;
        IFID_Rs = 4'd3; IFID_UsesRs = 1'b1; BranchTaken = 1'b1;
        #1;
        total++;
        if ({PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble} !== 6'b111111) begin
            bad++;
            $display("FAIL branch_ctrl got=%b want=111111",
                     {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble});
        end
        @(negedge clk);
        total++;
        if ({FlushCnt, StallCnt} !== {16'd1, 16'd0}) begin
            bad++;
            $display("FAIL branch_counts flush=%0d stall=%0d want 1/0", FlushCnt, StallCnt);
        end
        idle();
    endtask

    task automatic test_mem_wait();
        doReset();
        MemReq = 1'b1; MemDone = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble} !== 6'b000000) begin
                bad++;
                $display("FAIL memwait_freeze cyc=%0d got=%b want=000000", i,
                         {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble});
            end
            @(negedge clk);
        end
        MemDone = 1'b1;
        #1;
        total++;
        if ({PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble} !== 6'b111100) begin
            bad++;
            $display("FAIL memwait_release got=%b want=111100",
                     {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble});
        end
        @(negedge clk);
        total++;
        if ({MemErr, StallCnt} !== {1'b0, 16'd4}) begin
            bad++;
            $display("FAIL memwait_stallcnt err=%b stall=%0d want 0/4", MemErr, StallCnt);
        end
        MemReq = 1'b0; MemDone = 1'b0;
        #1;
        total++;
        if ({PC_wen, EXMEM_wen} !== 2'b11) begin
            bad++;
            $display("FAIL memwait_back_to_run got=%b want=11", {PC_wen, EXMEM_wen});
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        doReset();
        MemReq = 1'b1; MemDone = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            total++;
            if ({PC_wen, EXMEM_wen, MemErr} !== 3'b000) begin
                bad++;
                $display("FAIL timeout_wait cyc=%0d got=%b want=000", i, {PC_wen, EXMEM_wen, MemErr});
            end
            @(negedge clk);
        end
        total++;
        if ({MemErr, StallCnt} !== {1'b1, 16'd15}) begin
            bad++;
            $display("FAIL timeout_err err=%b stall=%0d want 1/15", MemErr, StallCnt);
        end
        MemDone = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({PC_wen, IFID_wen, MemErr} !== 3'b001) begin
                bad++;
                $display("FAIL timeout_sticky cyc=%0d got=%b want=001", i, {PC_wen, IFID_wen, MemErr});
            end
            @(negedge clk);
        end
        total++;
        if (StallCnt !== 16'd18) begin
            bad++;
            $display("FAIL timeout_stallcnt got=%0d want=18", StallCnt);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({MemErr, StallCnt, FlushCnt} !== 33'd0) begin
            bad++;
            $display("FAIL timeout_async_clear err=%b stall=%0d flush=%0d want 0", MemErr, StallCnt, FlushCnt);
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
    endtask

    task automatic test_reset_midwait();
        doReset();
        MemReq = 1'b1; MemDone = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble} !== 6'b000011) begin
            bad++;
            $display("FAIL midwait_in_reset got=%b want=000011",
                     {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble});
        end
        @(negedge clk);
        rst = 1'b1;
        MemReq = 1'b0;
        #1;
        total++;
        if ({PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble} !== 6'b111100) begin
            bad++;
            $display("FAIL midwait_first_run got=%b want=111100",
                     {PC_wen, IFID_wen, IDEX_wen, EXMEM_wen, IFID_flush, IDEX_bubble});
        end
        @(negedge clk);
        // A fresh wait must get the full 15-cycle budget.
        MemReq = 1'b1;
        repeat (14) @(negedge clk);
        total++;
        if (MemErr !== 1'b0) begin
            bad++;
            $display("FAIL midwait_counter_cleared err=%b want=0", MemErr);
        end
        @(negedge clk);
        total++;
        if (MemErr !== 1'b1) begin
            bad++;
            $display("FAIL midwait_full_timeout err=%b want=1", MemErr);
        end
        idle();
    endtask

    task automatic test_random();
        int mode, waitN, stallN, flushN, doneOdds;
        bit lu, frozen, eFlush, eBubble, ePc, eIfid, eWen;
        for (int seg = 0; seg < 4; seg++) begin
            doReset();
            mode = 0; waitN = 0; stallN = 0; flushN = 0;
            doneOdds = (seg == 3) ? 15 : 3;
            for (int c = 0; c < 80; c++) begin
                IFID_Rs = 4'($urandom_range(0, 3));
                IFID_Rt = 4'($urandom_range(0, 3));
                IDEX_Rd = 4'($urandom_range(0, 3));
                IFID_UsesRs = 1'($urandom_range(0, 1));
                IFID_UsesRt = 1'($urandom_range(0, 1));
                IDEX_MemRead = 1'($urandom_range(0, 1));
                IDEX_WriteReg = ($urandom_range(0, 3) != 0);
                BranchTaken = ($urandom_range(0, 4) == 0);
                MemReq = ($urandom_range(0, 3) == 0);
                MemDone = ($urandom_range(0, doneOdds) == 0);
                lu = IDEX_MemRead && IDEX_WriteReg && (IDEX_Rd != 0) &&
                     ((IFID_UsesRs && IFID_Rs == IDEX_Rd) || (IFID_UsesRt && IFID_Rt == IDEX_Rd));
                frozen = (mode == 2) || (mode == 1 && !MemDone) || (mode == 0 && MemReq && !MemDone);
                eFlush  = !frozen && BranchTaken;
                eBubble = !frozen && (BranchTaken || lu);
                ePc     = !frozen && (BranchTaken || !lu);
                eIfid   = ePc;
                eWen    = !frozen;
                #1;
                total++;
                if ({PC_wen, IFID_wen, IFID_flush, IDEX_wen, IDEX_bubble, EXMEM_wen, MemErr} !==
                    {ePc, eIfid, eFlush, eWen, eBubble, eWen, (mode == 2)}) begin
                    bad++;
                    $display("FAIL rand_ctrl seg=%0d cyc=%0d got=%b want=%b", seg, c,
                             {PC_wen, IFID_wen, IFID_flush, IDEX_wen, IDEX_bubble, EXMEM_wen, MemErr},
                             {ePc, eIfid, eFlush, eWen, eBubble, eWen, (mode == 2)});
                end
                @(negedge clk);
                if (!ePc && stallN < 65535) stallN++;
                if (eFlush && flushN < 65535) flushN++;
                if (mode == 0 && MemReq && !MemDone) begin
                    mode = 1; waitN = 1;
                end else if (mode == 1) begin
                    if (MemDone) mode = 0;
                    else begin
                        waitN++;
                        if (waitN >= 15) mode = 2;
                    end
                end
                total++;
                if ({StallCnt, FlushCnt} !== {16'(stallN), 16'(flushN)}) begin
                    bad++;
                    $display("FAIL rand_counts seg=%0d cyc=%0d got=%0d/%0d want=%0d/%0d",
                             seg, c, StallCnt, FlushCnt, stallN, flushN);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero();
        test_branch_loaduse();
        test_mem_wait();
        test_timeout();
        test_reset_midwait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_ctrl.md
Name: id_ex_hazard_ctrl

Overview:
Drives the write side of the ID/EX pipeline register. It decides each cycle whether ID/EX captures the decoded instruction, captures a bubble (all control bits zeroed), or holds its value. It also gates PC, IF/ID and EX/MEM writes, handles load-use stalls, taken-branch flushes and multi-cycle data-memory waits, and keeps stall/flush performance counters.

Parameters:
REG_BITS, 4, register-specifier width
CNT_WIDTH, 16, width of the stall and flush performance counters
MEM_TIMEOUT, 15, maximum MEMWAIT cycles before the error state

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
IFID_Rs  in  REG_BITS  source reg 1 of instruction in ID
IFID_Rt  in  REG_BITS  source reg 2 of instruction in ID
IFID_UsesRs  in  1  ID instruction reads Rs
IFID_UsesRt  in  1  ID instruction reads Rt
IDEX_Rd  in  REG_BITS  destination of instruction in EX (ID/EX output)
IDEX_MemRead  in  1  EX instruction is a load (ID/EX output)
IDEX_WriteReg  in  1  EX instruction writes a register (ID/EX output)
BranchTaken  in  1  branch resolved taken in EX this cycle
MemReq  in  1  MEM stage has an active data-memory access
MemDone  in  1  data memory completes the access this cycle
PC_wen  out  1  PC write enable
IFID_wen  out  1  IF/ID write enable
IFID_flush  out  1  IF/ID loads a NOP
IDEX_wen  out  1  ID/EX write enable
IDEX_bubble  out  1  ID/EX loads zeroed control bits instead of decode outputs
EXMEM_wen  out  1  EX/MEM write enable
MemErr  out  1  sticky memory-timeout error
StallCnt  out  CNT_WIDTH  cycles with PC_wen=0, saturating
FlushCnt  out  CNT_WIDTH  branch flushes taken, saturating

Behaviour:
- Reset (rst=0, async): state=RUN, wait counter=0, MemErr=0, StallCnt=0, FlushCnt=0. While rst=0: all wen=0, IFID_flush=1, IDEX_bubble=1.
- Load-use detection is combinational: load_use = IDEX_MemRead & IDEX_WriteReg & (IDEX_Rd!=0) & ((IFID_UsesRs & IFID_Rs==IDEX_Rd) | (IFID_UsesRt & IFID_Rt==IDEX_Rd)). Register 0 never hazards.
- Defaults: all wen=1, flush=0, bubble=0.
- State RUN, in priority order:
  - MemReq & !MemDone: freeze. All four wen=0, no flush or bubble. Next state MEMWAIT, wait counter=1. This has priority over branch and load-use; the branch/hazard is re-evaluated after the release.
  - else BranchTaken: IFID_flush=1, IDEX_bubble=1, all wen=1 (PC loads target). Overrides load_use in the same cycle.
  - else load_use: PC_wen=0, IFID_wen=0, IDEX_bubble=1, IDEX_wen=1, EXMEM_wen=1. Exactly one bubble per load, because the next cycle IDEX_MemRead is 0.
  - MemReq & MemDone in RUN means a single-cycle access: no stall.
- State MEMWAIT:
  - All wen=0 while !MemDone. The wait counter increments each cycle.
  - MemDone: outputs equal the RUN-state evaluation of the other inputs (branch/load_use may act this cycle). Next state RUN, counter cleared.
  - Counter reaches MEM_TIMEOUT without MemDone: next state ERR.
- State ERR: MemErr=1, all wen=0. Leaves only on reset; MemDone is ignored.
- StallCnt increments on every clock edge where PC_wen=0 and rst=1, including ERR. Saturates at all-ones.
- FlushCnt increments on every cycle with IFID_flush=1 and rst=1. Saturates at all-ones.
- No other registered outputs; control outputs are combinational from state and inputs, so latency is 0 cycles.

Test Plan:
- Load-use: IDEX_MemRead=1, IDEX_WriteReg=1, IDEX_Rd=3, IFID_Rs=3, UsesRs=1 -> one cycle of PC_wen=0, IFID_wen=0, IDEX_bubble=1; next cycle (MemRead=0) all wen=1; StallCnt=1.
- Rd=0: same as above with IDEX_Rd=0, IFID_Rs=0 -> no stall, StallCnt stays 0.
- Branch with load-use in the same cycle: BranchTaken=1 and load_use=1 -> IFID_flush=1, IDEX_bubble=1, PC_wen=1; FlushCnt=1, StallCnt=0.
- Memory wait: MemReq=1, MemDone=0 for 4 cycles, then MemDone=1 -> 4 frozen cycles (all wen=0), release on the 5th cycle, state RUN; StallCnt=4.
- Timeout: MemReq=1, MemDone never asserted -> after 15 frozen cycles MemErr=1 and stays 1; a later MemDone=1 does not release; rst=0 clears MemErr and the counters immediately (asynchronously).
- Reset mid-MEMWAIT: assert rst=0 at wait count 7 -> state RUN with counter 0 after release, and all wen=1 on the first cycle with MemReq=0.
